// File: rtl/dds_pkg.sv
// Shared types and constants for the multi-waveform DDS oscillator.
// Contents:
//   wave_mode_t  waveform selector (triangle, sawtooth, square, sine)
//   GAIN_ONE     unity gain for the default 16-bit Q1.15 gain input
//   DDS_LATENCY  clocks from tick cycle to out_valid
//   DUTY_RESET   square duty threshold after reset (50 %)
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_TRI = 2'd0,
    WAVE_SAW = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_SIN = 2'd3
  } wave_mode_t;

  localparam logic [15:0] GAIN_ONE    = 16'h8000;
  localparam int unsigned DDS_LATENCY = 3;
  localparam logic [7:0]  DUTY_RESET  = 8'h80;

endpackage

// File: rtl/multi_wave_dds_sine_lut.sv
// Quarter-wave sine ROM with a registered read.
// Entry i = round((2^(OUT_W-1)-1) * sin(2*pi*(i+0.5)/2^ADDR_W)); the half-LSB
// phase shift makes the quarter symmetric so the other three quarters are
// produced by index inversion and negation in the caller.
// Ports:
//   clk_i   clock
//   addr_i  quarter-table index, ADDR_W-2 bits
//   data_o  unsigned magnitude, OUT_W-1 bits, valid one clock after addr_i
module sine_quarter_lut #(
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic [ADDR_W-3:0] addr_i,
  output logic [OUT_W-2:0]  data_o
);

  localparam int  DEPTH = 2 ** (ADDR_W - 2);
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = real'((2 ** (OUT_W - 1)) - 1);

  logic [OUT_W-2:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real ANG = 2.0 * PI * (real'(i) + 0.5) / real'(2 ** ADDR_W);
    assign rom[i] = (OUT_W-1)'($rtoi(AMP * $sin(ANG) + 0.5));
  end

  always_ff @(posedge clk_i) begin
    data_o <= rom[addr_i];
  end

endmodule

// File: rtl/multi_wave_dds.sv
// Multi-waveform DDS oscillator: triangle, sawtooth, square (programmable
// duty) or sine, with phase offset, Q1.(GAIN_W-1) gain and saturation.
// Three-stage pipeline: phase accumulate, waveform lookup, gain/saturate.
// Mode and duty are held in active registers that only reload on a phase
// wrap or on sync, so a waveform never switches mid-period.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   sample_en_i        advance phase and emit one sample
//   sync_i             zero the phase, load mode/duty, emit one sample
//   phase_step_i       tuning word
//   phase_offset_i     added to the phase before lookup only
//   mode_i, duty_i     pending waveform select and square threshold
//   gain_i             output gain, unsigned Q1.(GAIN_W-1)
//   sample_out_o       signed sample, held between valid pulses
//   out_valid_o        one pulse per sample
//   wrap_out_o         sample came from a wrapping accumulation
module multi_wave_dds
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16,
  parameter int ADDR_W  = 10,
  parameter int GAIN_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sample_en_i,
  input  logic               sync_i,
  input  logic [PHASE_W-1:0] phase_step_i,
  input  logic [PHASE_W-1:0] phase_offset_i,
  input  logic [1:0]         mode_i,
  input  logic [7:0]         duty_i,
  input  logic [GAIN_W-1:0]  gain_i,
  output logic [OUT_W-1:0]   sample_out_o,
  output logic               out_valid_o,
  output logic               wrap_out_o
);

  localparam int P  = PHASE_W - 1;
  localparam int QW = ADDR_W - 2;
  localparam int PW = OUT_W + GAIN_W + 1;

  localparam logic signed [OUT_W-1:0] SQR_HI = OUT_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [OUT_W-1:0] SQR_LO = -SQR_HI;
  localparam logic signed [PW-1:0]    SAT_HI = PW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PW-1:0]    SAT_LO = -SAT_HI - PW'(1);
  localparam logic signed [PW-1:0]    RND    = PW'(2 ** (GAIN_W - 2));

  // stage 1: accumulator and active mode/duty
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               v1_q, v1_d, wrap1_q, wrap1_d;
  wave_mode_t         mode_q, mode_d;
  logic [7:0]         duty_q, duty_d;

  always_comb begin
    acc_d   = acc_q;
    v1_d    = 1'b0;
    wrap1_d = wrap1_q;
    mode_d  = mode_q;
    duty_d  = duty_q;
    if (sync_i) begin
      acc_d   = '0;
      v1_d    = 1'b1;
      wrap1_d = 1'b0;
      mode_d  = wave_mode_t'(mode_i);
      duty_d  = duty_i;
    end else if (sample_en_i) begin
      {wrap1_d, acc_d} = {1'b0, acc_q} + {1'b0, phase_step_i};
      v1_d = 1'b1;
      if (wrap1_d) begin
        mode_d = wave_mode_t'(mode_i);
        duty_d = duty_i;
      end
    end
  end

  // stage 2: waveform lookup from the post-update accumulator
  logic [PHASE_W-1:0] ph;
  logic [OUT_W-1:0]   u, f, raw_tri, raw_saw, raw_sqr, raw2_d, raw2_q;
  logic [QW-1:0]      lut_addr;
  logic [OUT_W-2:0]   lut_data;
  logic               v2_q, wrap2_q, sin2_q, neg2_q;

  always_comb begin
    ph      = acc_q + phase_offset_i;
    u       = ph[P-1 -: OUT_W];
    f       = ph[P] ? ~u : u;
    raw_tri = {~f[OUT_W-1], f[OUT_W-2:0]};
    raw_saw = {~ph[P], ph[P-1 -: OUT_W-1]};
    raw_sqr = (ph[P -: 8] < duty_q) ? SQR_HI : SQR_LO;
    // second and fourth quarters read the table backwards
    lut_addr = ph[P-1] ? ~ph[P-2 -: QW] : ph[P-2 -: QW];
    unique case (mode_q)
      WAVE_TRI: raw2_d = raw_tri;
      WAVE_SAW: raw2_d = raw_saw;
      WAVE_SQR: raw2_d = raw_sqr;
      default:  raw2_d = '0;
    endcase
  end

  sine_quarter_lut #(
    .OUT_W  (OUT_W),
    .ADDR_W (ADDR_W)
  ) u_lut (
    .clk_i  (clk_i),
    .addr_i (lut_addr),
    .data_o (lut_data)
  );

  // stage 3: gain, round half up, saturate
  logic signed [OUT_W-1:0]  raw3;
  logic signed [GAIN_W:0]   gain_s;
  logic signed [PW-1:0]     prod, scaled;
  logic [OUT_W-1:0]         y;

  always_comb begin
    if (sin2_q) begin
      raw3 = neg2_q ? -$signed({1'b0, lut_data}) : $signed({1'b0, lut_data});
    end else begin
      raw3 = $signed(raw2_q);
    end
    gain_s = $signed({1'b0, gain_i});
    prod   = PW'(raw3) * PW'(gain_s);
    scaled = (prod + RND) >>> (GAIN_W - 1);
    if (scaled > SAT_HI) begin
      y = SAT_HI[OUT_W-1:0];
    end else if (scaled < SAT_LO) begin
      y = SAT_LO[OUT_W-1:0];
    end else begin
      y = scaled[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q        <= '0;
      v1_q         <= 1'b0;
      wrap1_q      <= 1'b0;
      mode_q       <= WAVE_TRI;
      duty_q       <= DUTY_RESET;
      v2_q         <= 1'b0;
      wrap2_q      <= 1'b0;
      sample_out_o <= '0;
      out_valid_o  <= 1'b0;
      wrap_out_o   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      v1_q         <= v1_d;
      wrap1_q      <= wrap1_d;
      mode_q       <= mode_d;
      duty_q       <= duty_d;
      v2_q         <= v1_q;
      wrap2_q      <= wrap1_q;
      out_valid_o  <= v2_q;
      wrap_out_o   <= v2_q & wrap2_q;
      if (v2_q) begin
        sample_out_o <= y;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    raw2_q <= raw2_d;
    sin2_q <= (mode_q == WAVE_SIN);
    neg2_q <= ph[P];
  end

endmodule

// File: tb/tb_multi_wave_dds.sv
module tb_multi_wave_dds;
  import dds_pkg::*;

  localparam int  NC = 4096;
  localparam real PI = 3.14159265358979323846;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sample_en_i = 1'b0;
  logic        sync_i = 1'b0;
  logic [31:0] phase_step_i = '0;
  logic [31:0] phase_offset_i = '0;
  logic [1:0]  mode_i = '0;
  logic [7:0]  duty_i = 8'h80;
  logic [15:0] gain_i = GAIN_ONE;
  logic [15:0] sample_out_o;
  logic        out_valid_o;
  logic        wrap_out_o;

  multi_wave_dds dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_en_i    (sample_en_i),
    .sync_i         (sync_i),
    .phase_step_i   (phase_step_i),
    .phase_offset_i (phase_offset_i),
    .mode_i         (mode_i),
    .duty_i         (duty_i),
    .gain_i         (gain_i),
    .sample_out_o   (sample_out_o),
    .out_valid_o    (out_valid_o),
    .wrap_out_o     (wrap_out_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  int d;

  // expectations indexed by the cycle in which the sample must be visible
  bit exp_v [NC];
  bit exp_w [NC];
  int exp_s [NC];
  int exp_tol [NC];
  bit fix_v [NC];
  int fix_s [NC];

  // reference state
  longint unsigned m_acc = 0;
  int m_mode = 0;
  int m_duty = 128;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Ideal waveforms from the phase as a number in [0, 2^32).
  function automatic int wave(input longint unsigned p, input int md, input int dt);
    real s;
    case (md)
      0: return (p < 64'h8000_0000) ? int'(p >> 15) - 32768
                                    : 32767 - int'((p - 64'h8000_0000) >> 15);
      1: return int'(p >> 16) - 32768;
      2: return (int'(p >> 24) < dt) ? 32767 : -32767;
      default: begin
        s = 32767.0 * $sin(2.0 * PI * (real'(p >> 22) + 0.5) / 1024.0);
        return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
      end
    endcase
  endfunction

  function automatic int apply_gain(input int raw, input int g);
    longint y;
    y = (longint'(raw) * longint'(g) + 16384) >>> 15;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  task automatic drive(input bit en, input bit sy, input int md, input int dt,
                       input bit has_fix = 1'b0, input int fix = 0);
    longint unsigned nxt;
    bit wr;
    int c;
    @(posedge clk_i); #1;
    sample_en_i = en;
    sync_i      = sy;
    mode_i      = md[1:0];
    duty_i      = dt[7:0];
    wr = 1'b0;
    if (sy) begin
      m_acc  = 0;
      m_mode = md;
      m_duty = dt;
    end else if (en) begin
      nxt   = m_acc + longint'(phase_step_i);
      wr    = (nxt >= 64'h1_0000_0000);
      m_acc = nxt % 64'h1_0000_0000;
      if (wr) begin
        m_mode = md;
        m_duty = dt;
      end
    end
    if (sy || en) begin
      c = cyc + DDS_LATENCY;
      exp_v[c]   = 1'b1;
      exp_w[c]   = wr;
      exp_s[c]   = apply_gain(wave((m_acc + longint'(phase_offset_i)) % 64'h1_0000_0000,
                                   m_mode, m_duty), int'(gain_i));
      exp_tol[c] = (m_mode == 3) ? 1 : 0;
      fix_v[c]   = has_fix;
      fix_s[c]   = fix;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, int'(mode_i), int'(duty_i));
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    sample_en_i = 1'b0;
    sync_i = 1'b0;
    for (int k = cyc + 1; k < cyc + 8 && k < NC; k++) begin
      exp_v[k] = 1'b0;
      exp_w[k] = 1'b0;
      fix_v[k] = 1'b0;
    end
    m_acc = 0;
    m_mode = 0;
    m_duty = 128;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (mon_en && cyc < NC) begin
      total++;
      assert (out_valid_o === exp_v[cyc]) else begin
        bad++;
        $error("FAIL valid cyc=%0d got=%b want=%b", cyc, out_valid_o, exp_v[cyc]);
      end
      total++;
      assert (wrap_out_o === exp_w[cyc]) else begin
        bad++;
        $error("FAIL wrap cyc=%0d got=%b want=%b", cyc, wrap_out_o, exp_w[cyc]);
      end
      if (exp_v[cyc]) begin
        d = int'($signed(sample_out_o)) - exp_s[cyc];
        total++;
        assert (!$isunknown(sample_out_o) && d >= -exp_tol[cyc] && d <= exp_tol[cyc]) else begin
          bad++;
          $error("FAIL sample cyc=%0d got=%0d want=%0d", cyc, $signed(sample_out_o), exp_s[cyc]);
        end
        if (fix_v[cyc]) begin
          total++;
          assert (int'($signed(sample_out_o)) === fix_s[cyc]) else begin
            bad++;
            $error("FAIL directed cyc=%0d got=%0d want=%0d", cyc, $signed(sample_out_o), fix_s[cyc]);
          end
        end
      end
    end
  end

  initial begin
    // reset state, then one tick at zero phase
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    total++;
    assert (sample_out_o === 16'h0000) else begin
      bad++;
      $error("FAIL rst_sample got=%h want=0000", sample_out_o);
    end
    total++;
    assert (out_valid_o === 1'b0 && wrap_out_o === 1'b0) else begin
      bad++;
      $error("FAIL rst_flags got=%b%b want=00", out_valid_o, wrap_out_o);
    end
    mon_en = 1'b1;
    drive(1'b1, 1'b0, 0, 128, 1'b1, -32768);

    // triangle through a full period, back-to-back
    idle(1);
    phase_step_i = 32'h0100_0000;
    for (int k = 1; k <= 256; k++) begin
      if (k == 128)      drive(1'b1, 1'b0, 0, 128, 1'b1, 32767);
      else if (k == 256) drive(1'b1, 1'b0, 0, 128, 1'b1, -32768);
      else               drive(1'b1, 1'b0, 0, 128);
    end

    // mode request mid-period only takes effect at the wrap
    for (int k = 1; k <= 384; k++) begin
      if (k == 255)      drive(1'b1, 1'b0, 2, 128, 1'b1, -32257);
      else if (k == 256) drive(1'b1, 1'b0, 2, 128, 1'b1, 32767);
      else if (k == 384) drive(1'b1, 1'b0, 2, 128, 1'b1, -32767);
      else               drive(1'b1, 1'b0, (k >= 50) ? 2 : 0, 128);
    end

    // sine with sync at quarter-period steps
    idle(4);
    phase_step_i = 32'h4000_0000;
    drive(1'b0, 1'b1, 3, 128, 1'b1, 101);
    repeat (3) drive(1'b1, 1'b0, 3, 128);

    // gain and saturation at triangle peak and trough
    idle(4);
    phase_step_i = 32'h8000_0000;
    gain_i = 16'hFFFF;
    drive(1'b0, 1'b1, 0, 128, 1'b1, -32768);
    drive(1'b1, 1'b0, 0, 128, 1'b1, 32767);
    idle(4);
    gain_i = 16'h4000;
    drive(1'b0, 1'b1, 0, 128, 1'b1, -16384);
    drive(1'b1, 1'b0, 0, 128, 1'b1, 16384);
    idle(4);
    gain_i = 16'h0000;
    drive(1'b0, 1'b1, 0, 128, 1'b1, 0);
    drive(1'b1, 1'b0, 0, 128, 1'b1, 0);

    // reset drops an in-flight sample; sync wins over sample_en
    idle(4);
    gain_i = GAIN_ONE;
    phase_step_i = 32'h0100_0000;
    drive(1'b1, 1'b0, 0, 128);
    do_reset();
    idle(5);
    repeat (3) drive(1'b1, 1'b0, 0, 128);
    drive(1'b1, 1'b1, 0, 128, 1'b1, -32768);

    // randomized batches against the reference model
    for (int b = 0; b < 6; b++) begin
      idle(4);
      phase_step_i   = $urandom;
      phase_offset_i = $urandom;
      gain_i         = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 60; i++) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      end
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
